// File: rtl/canvas_capture_pkg.sv
// Shared definitions for the canvas capture block: FSM encoding, canvas geometry
// and the {row, col} address composition used by every canvas access.
`timescale 1ns/1ps
package canvas_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    localparam int GRID_BITS    = 5;
    localparam int ADDR_BITS    = 2 * GRID_BITS;
    localparam int CANVAS_DEPTH = 1024;
    localparam int CROP_BEATS   = 784;

    function automatic logic [ADDR_BITS-1:0] canvas_addr(
        input logic [GRID_BITS-1:0] row,
        input logic [GRID_BITS-1:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/canvas_capture_ram.sv
// 1-bit canvas storage: one write port and two independent registered read ports.
// No reset so it maps onto block RAM; read-during-write returns the old bit.
`timescale 1ns/1ps
module canvas_ram #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic              rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic              rdata_b_o
);

    logic mem_q [DEPTH];
    logic rdata_a_q;
    logic rdata_b_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_a_q <= mem_q[raddr_a_i];
        rdata_b_q <= mem_q[raddr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/canvas_capture.sv
// Accumulates cursor strokes into a 32x32 bit canvas and streams the centred
// 28x28 crop to the classifier over valid/ready; also serves a display read port.
`timescale 1ns/1ps
module canvas_capture
    import canvas_capture_pkg::*;
#(
    parameter int GRID_W   = 5,
    parameter int COORD_W  = 8,
    parameter int CROP_OFS = 2,
    parameter int CROP_N   = 28
) (
    input  logic               iBusClk,
    input  logic               iRstN,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic               iDraw,
    input  logic               iClear,
    input  logic               iStart,
    output logic               oPix,
    output logic               oValid,
    input  logic               iReady,
    output logic               oLast,
    output logic               oBusy,
    input  logic [GRID_W-1:0]  iRdX,
    input  logic [GRID_W-1:0]  iRdY,
    output logic               oRdPix
);

    localparam int AW = 2 * GRID_W;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [GRID_W-1:0] row_q, row_d;
    logic [GRID_W-1:0] col_q, col_d;
    logic              valid_q, valid_d;
    logic              live_q;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic              ram_wdata;
    logic [AW-1:0]     disp_addr;
    logic [AW-1:0]     stream_addr;
    logic              disp_pix;
    logic              stream_pix;
    logic              last_beat;
    logic              unused_coord_bits;

    assign unused_coord_bits = ^{iX[COORD_W-GRID_W-1:0], iY[COORD_W-GRID_W-1:0]};

    assign last_beat = (row_q == GRID_W'(CROP_N - 1)) && (col_q == GRID_W'(CROP_N - 1));

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        ram_we    = 1'b0;
        ram_waddr = canvas_addr(iY[COORD_W-1 -: GRID_W], iX[COORD_W-1 -: GRID_W]);
        ram_wdata = 1'b1;
        case (state_q)
            ST_IDLE: begin
                ram_we  = iDraw;
                row_d   = '0;
                col_d   = '0;
                valid_d = 1'b0;
                if (iClear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (iStart) begin
                    state_d = ST_STREAM;
                end
            end
            ST_CLEAR: begin
                // The first cycle after reset release only arms live_q, so a
                // reset-triggered clear spans the same 1024 busy cycles as iClear.
                if (live_q) begin
                    ram_we    = 1'b1;
                    ram_waddr = clr_cnt_q;
                    ram_wdata = 1'b0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STREAM: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (iReady) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end else if (col_q == GRID_W'(CROP_N - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fetch from the next-state counter: a stall re-reads the held beat, an
    // accept fetches the following one in time for back-to-back presentation.
    assign stream_addr = canvas_addr(row_d + GRID_W'(CROP_OFS), col_d + GRID_W'(CROP_OFS));
    assign disp_addr   = canvas_addr(iRdY, iRdX);

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            live_q    <= 1'b1;
        end
    end

    canvas_ram #(
        .ADDR_W (AW),
        .DEPTH  (CANVAS_DEPTH)
    ) u_ram (
        .clk_i     (iBusClk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .raddr_a_i (disp_addr),
        .rdata_a_o (disp_pix),
        .raddr_b_i (stream_addr),
        .rdata_b_o (stream_pix)
    );

    assign oValid = valid_q;
    assign oPix   = valid_q & stream_pix;
    assign oLast  = valid_q & last_beat;
    assign oBusy  = live_q & (state_q != ST_IDLE);
    assign oRdPix = live_q & disp_pix;

endmodule

// File: tb/tb_canvas_capture.sv
// Directed bench for canvas_capture: table-driven draw/readback vectors plus
// hand-written sequences for clear, streaming with stalls, and mid-frame reset.
`timescale 1ns/1ps
module tb_canvas_capture;

    logic       iBusClk = 1'b0;
    logic       iRstN   = 1'b0;
    logic [7:0] iX      = '0;
    logic [7:0] iY      = '0;
    logic       iDraw   = 1'b0;
    logic       iClear  = 1'b0;
    logic       iStart  = 1'b0;
    logic       iReady  = 1'b0;
    logic [4:0] iRdX    = '0;
    logic [4:0] iRdY    = '0;
    logic       oPix, oValid, oLast, oBusy, oRdPix;

    int n_chk  = 0;
    int n_fail = 0;
    logic ref_bm [32][32];

    canvas_capture dut (
        .iBusClk (iBusClk), .iRstN (iRstN),
        .iX (iX), .iY (iY), .iDraw (iDraw), .iClear (iClear), .iStart (iStart),
        .oPix (oPix), .oValid (oValid), .iReady (iReady), .oLast (oLast), .oBusy (oBusy),
        .iRdX (iRdX), .iRdY (iRdY), .oRdPix (oRdPix)
    );

    always #5 iBusClk = ~iBusClk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1);
    end

    typedef struct {
        logic       draw;
        logic [7:0] x;
        logic [7:0] y;
        logic [4:0] rdx;
        logic [4:0] rdy;
        logic       exp;
    } vec_t;

    task automatic step();
        @(posedge iBusClk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_busy(output int cnt, output int vseen);
        cnt = 0;
        vseen = 0;
        while (oBusy && cnt < 3000) begin
            if (oValid) vseen++;
            cnt++;
            step();
        end
    endtask

    task automatic draw_cell(input logic [7:0] x, input logic [7:0] y);
        iX = x;
        iY = y;
        iDraw = 1'b1;
        step();
        iDraw = 1'b0;
        ref_bm[y[7:3]][x[7:3]] = 1'b1;
    endtask

    task automatic run_stream(input bit stall, input string tag);
        int beats, pix_err, last_err, hold_err, first_cyc, last_cyc;
        bit prev_stall, done;
        logic prev_pix, prev_last, exp_pix;
        beats = 0; pix_err = 0; last_err = 0; hold_err = 0;
        first_cyc = 0; last_cyc = 0; prev_stall = 0; done = 0;
        prev_pix = 0; prev_last = 0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            iReady = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (prev_stall && (oValid !== 1'b1 || oPix !== prev_pix || oLast !== prev_last))
                hold_err++;
            prev_stall = oValid && !iReady;
            prev_pix   = oPix;
            prev_last  = oLast;
            if (oValid && iReady) begin
                exp_pix = ref_bm[beats / 28 + 2][beats % 28 + 2];
                if (oPix !== exp_pix) pix_err++;
                if (oLast !== (beats == 783)) last_err++;
                if (beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
                if (oLast) done = 1;
            end
            step();
        end
        iReady = 1'b0;
        chk({tag, "_beats"}, beats, 784);
        chk({tag, "_pix_errors"}, pix_err, 0);
        chk({tag, "_last_errors"}, last_err, 0);
        chk({tag, "_stall_hold_errors"}, hold_err, 0);
        if (!stall) chk({tag, "_beat_span"}, last_cyc - first_cyc, 783);
        chk({tag, "_busy_after"}, int'(oBusy), 0);
        chk({tag, "_valid_after"}, int'(oValid), 0);
    endtask

    initial begin
        vec_t vecs[9];
        int cnt, vseen, nz, acc;

        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                ref_bm[r][c] = 1'b0;

        vecs[0] = '{1'b1, 8'h40, 8'h80, 5'd8,  5'd16, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 5'd7,  5'd16, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 8'h00, 5'd9,  5'd16, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 5'd8,  5'd15, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 5'd31, 5'd31, 1'b1};
        vecs[5] = '{1'b1, 8'h07, 8'h00, 5'd0,  5'd0,  1'b1};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 5'd1,  5'd0,  1'b0};
        vecs[7] = '{1'b1, 8'h17, 8'h10, 5'd2,  5'd2,  1'b1};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 5'd8,  5'd16, 1'b1};

        // Reset state
        repeat (3) step();
        chk("rst_valid", int'(oValid), 0);
        chk("rst_busy",  int'(oBusy),  0);
        chk("rst_last",  int'(oLast),  0);
        chk("rst_pix",   int'(oPix),   0);
        chk("rst_rdpix", int'(oRdPix), 0);
        iRstN = 1'b1;
        step();
        wait_busy(cnt, vseen);
        chk("init_clear_busy_cycles", cnt, 1024);
        chk("init_clear_valid_seen", vseen, 0);

        nz = 0;
        for (int a = 0; a < 1024; a++) begin
            iRdY = 5'(a >> 5);
            iRdX = 5'(a & 31);
            step();
            if (oRdPix !== 1'b0) nz++;
        end
        chk("init_canvas_nonzero", nz, 0);

        // Draw / readback vectors
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].draw) draw_cell(vecs[i].x, vecs[i].y);
            iRdX = vecs[i].rdx;
            iRdY = vecs[i].rdy;
            step();
            chk($sformatf("rd_vec%0d", i), int'(oRdPix), int'(vecs[i].exp));
        end

        // Clear, then stream with two corner cells
        iClear = 1'b1;
        step();
        iClear = 1'b0;
        wait_busy(cnt, vseen);
        chk("clear_busy_cycles", cnt, 1024);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                ref_bm[r][c] = 1'b0;
        iRdX = 5'd8; iRdY = 5'd16;
        step();
        chk("clear_erased_8_16", int'(oRdPix), 0);
        draw_cell(8'd16, 8'd16);
        draw_cell(8'd232, 8'd232);
        run_stream(1'b0, "stream_full");
        run_stream(1'b1, "stream_stall");

        // Draw during STREAM is suppressed; draw in IDLE lands
        iReady = 1'b0;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        iX = 8'd80; iY = 8'd80; iDraw = 1'b1;
        repeat (5) step();
        chk("stream_stalled_valid", int'(oValid), 1);
        iDraw = 1'b0;
        iReady = 1'b1;
        cnt = 0;
        while (oBusy && cnt < 2000) begin cnt++; step(); end
        chk("drain_busy_low", int'(oBusy), 0);
        iReady = 1'b0;
        iRdX = 5'd10; iRdY = 5'd10;
        step();
        chk("draw_in_stream_ignored", int'(oRdPix), 0);
        draw_cell(8'd80, 8'd80);
        step();
        chk("draw_in_idle_written", int'(oRdPix), 1);

        // Clear and start together: clear wins
        iClear = 1'b1; iStart = 1'b1;
        step();
        iClear = 1'b0; iStart = 1'b0;
        wait_busy(cnt, vseen);
        chk("clr_start_busy_cycles", cnt, 1024);
        chk("clr_start_valid_seen", vseen, 0);
        step();
        chk("clr_start_erased_10_10", int'(oRdPix), 0);

        // Reset at beat 300 aborts the frame and re-clears the canvas
        draw_cell(8'd16, 8'd16);
        iReady = 1'b1;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        acc = 0;
        cnt = 0;
        while (acc < 300 && cnt < 1000) begin
            if (oValid && iReady) acc++;
            cnt++;
            step();
        end
        chk("abort_beats_before_reset", acc, 300);
        chk("abort_valid_before_reset", int'(oValid), 1);
        iRstN = 1'b0;
        #1;
        chk("abort_valid_async", int'(oValid), 0);
        chk("abort_last_async", int'(oLast), 0);
        chk("abort_busy_async", int'(oBusy), 0);
        iReady = 1'b0;
        step();
        step();
        iRstN = 1'b1;
        step();
        wait_busy(cnt, vseen);
        chk("abort_clear_busy_cycles", cnt, 1024);
        iRdX = 5'd2; iRdY = 5'd2;
        step();
        chk("abort_canvas_cleared", int'(oRdPix), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
